// File: rtl/mem_dump_unit_pkg.sv
// mem_dump_unit_pkg: state encoding and default parameters shared by the dump unit and its users
package mem_dump_unit_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;
  localparam logic [31:0] TRAP_WORD_DEF  = 32'h44000300;
  localparam logic [31:0] BASE_ADDR_DEF  = 32'h2000;
  localparam logic [31:0] LIMIT_ADDR_DEF = 32'h2100;
  localparam int          DRAIN_CYCLES_DEF = 4;
  localparam int          DRAIN_CNT_W = 16;
endpackage

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: on the trap instruction, halts the core, drains stores, then streams a data-memory window out word by word
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter logic [31:0] TRAP_WORD    = TRAP_WORD_DEF,
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter logic [31:0] LIMIT_ADDR   = LIMIT_ADDR_DEF,
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  output logic        halt,
  output logic [31:0] rd_addr,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        done
);
  state_t state;
  logic [DRAIN_CNT_W-1:0] cnt;
  logic [31:0] addr;
  logic [32:0] next_addr;
  // one extra bit so a window ending near 2^32 still terminates instead of wrapping
  assign next_addr = {1'b0, addr} + 33'd4;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr       <= '0;
      halt       <= 1'b0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (instr_valid && instruction == TRAP_WORD) begin
          state <= S_DRAIN;
          halt  <= 1'b1;
          cnt   <= DRAIN_CNT_W'(DRAIN_CYCLES - 1);
        end
        S_DRAIN: if (cnt == '0) begin
          if (BASE_ADDR >= LIMIT_ADDR) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state   <= S_READ;
            addr    <= BASE_ADDR;
            rd_addr <= BASE_ADDR;
            rd_en   <= 1'b1;
          end
        end else cnt <= cnt - 1'b1;
        S_READ: begin
          rd_en <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          dump_data  <= rd_data;
          dump_addr  <= addr;
          dump_valid <= 1'b1;
          state      <= S_PRESENT;
        end
        S_PRESENT: if (dump_ready) begin
          dump_valid <= 1'b0;
          addr       <= next_addr[31:0];
          if (next_addr >= {1'b0, LIMIT_ADDR}) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state   <= S_READ;
            rd_en   <= 1'b1;
            rd_addr <= next_addr[31:0];
          end
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dump_unit.sv
// tb_mem_dump_unit: directed scoreboard bench for the dump unit, plus an empty-window instance
module tb_mem_dump_unit;
  typedef struct {logic [31:0] addr; logic [31:0] data;} word_t;
  localparam logic [31:0] TRAP = 32'h44000300;
  logic clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, dump_ready = 1'b1;
  logic [31:0] instruction = '0, rd_data = '0;
  logic halt, rd_en, dump_valid, done;
  logic [31:0] rd_addr, dump_addr, dump_data;
  logic e_halt, e_rd_en, e_dump_valid, e_done;
  logic [31:0] e_rd_addr, e_dump_addr, e_dump_data;
  int checks = 0, failures = 0, rd_cnt = 0, e_pulses = 0, e_reads = 0;
  word_t sb[$];

  always #5 clk = ~clk;

  mem_dump_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .halt(halt), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .done(done)
  );
  mem_dump_unit #(.BASE_ADDR(32'h2000), .LIMIT_ADDR(32'h2000)) dut_e (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .halt(e_halt), .rd_addr(e_rd_addr), .rd_en(e_rd_en), .rd_data(32'h0),
    .dump_valid(e_dump_valid), .dump_ready(1'b1), .dump_addr(e_dump_addr),
    .dump_data(e_dump_data), .done(e_done)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h2004 ? 32'hDEADBEEF : a == 32'h20FC ? 32'h00000037 : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_word(rd_addr);
  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (e_dump_valid) e_pulses++;
    if (e_rd_en) e_reads++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_all();
    for (int i = 0; i < 64; i++) sb.push_back('{32'h2000 + 32'(i * 4), mem_word(32'h2000 + 32'(i * 4))});
  endtask

  task automatic start_dump();
    int n = 0;
    @(negedge clk);
    chk("halt_before_trap", halt, 0);
    instruction = TRAP;
    instr_valid = 1'b1;
    push_all();
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = '0;
    chk("halt_plus1", halt, 1);
    while (!dump_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 3) chk("empty_done_early", e_done, 0);
      if (n == 4) chk("empty_done_after_drain", e_done, 1);
    end
    chk("first_valid_latency", n, 6);
  endtask

  task automatic collect(input logic [31:0] stall_at, input logic [31:0] stop_at, input int max_cycles);
    int cyc = 0;
    word_t exp;
    while (sb.size() > 0 && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (dump_valid) begin
        exp = sb[0];
        if (exp.addr == stop_at) begin
          dump_ready = 1'b0;
          chk("stop_addr", dump_addr, stop_at);
          return;
        end
        chk("dump_addr", dump_addr, exp.addr);
        chk("dump_data", dump_data, exp.data);
        if (exp.addr == stall_at) begin
          dump_ready = 1'b0;
          repeat (20) begin
            @(negedge clk);
            chk("stall_valid", dump_valid, 1);
            chk("stall_addr", dump_addr, exp.addr);
            chk("stall_data", dump_data, exp.data);
          end
          dump_ready = 1'b1;
        end
        void'(sb.pop_front());
        @(negedge clk);
        chk("gap1", dump_valid, 0);
        @(negedge clk);
        chk("gap2", dump_valid, 0);
        cyc += 2;
      end
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {28'h0, halt, rd_en, dump_valid, done}, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_dump_addr"}, dump_addr, 0);
    chk({tag, "_dump_data"}, dump_data, 0);
  endtask

  initial begin
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    // trap without instr_valid, then a near-miss opcode: both must be ignored
    instruction = TRAP;
    repeat (3) @(negedge clk);
    instruction = 32'h44000301;
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    instruction = '0;
    repeat (10) @(negedge clk);
    chk("ignore_halt", halt, 0);
    chk("ignore_reads", rd_cnt, 0);
    chk("ignore_empty_halt", e_halt, 0);
    // full dump with a 20-cycle stall on 0x2010
    start_dump();
    collect(32'h2010, 32'hFFFFFFFF, 3000);
    @(negedge clk);
    chk("done", done, 1);
    chk("done_halt", halt, 1);
    chk("done_valid", dump_valid, 0);
    chk("read_count", rd_cnt, 64);
    chk("empty_pulses", e_pulses, 0);
    chk("empty_reads", e_reads, 0);
    instruction = TRAP;
    instr_valid = 1'b1;
    repeat (5) @(negedge clk);
    instr_valid = 1'b0;
    instruction = '0;
    repeat (10) @(negedge clk);
    chk("retrap_done", done, 1);
    chk("retrap_valid", dump_valid, 0);
    chk("retrap_reads", rd_cnt, 64);
    // restart from reset, then abort asynchronously while 0x2040 is presented
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    start_dump();
    collect(32'hFFFFFFFF, 32'h2040, 2000);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    dump_ready = 1'b1;
    sb.delete();
    start_dump();
    chk("restart_addr", dump_addr, 32'h2000);
    collect(32'hFFFFFFFF, 32'hFFFFFFFF, 3000);
    @(negedge clk);
    chk("restart_done", done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
